// File: rtl/mskand_hpc2_sched_pkg.sv
// Shared constants and helpers for the HPC2 AND scheduler: widths, randomness indexing.
package mskand_hpc2_sched_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ID_W    = 1;

    function automatic int unsigned hpc2rnd_bits(input int unsigned d);
        return d * (d - 1) / 2;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bit of the randomness word shared by share pair {i,j}; symmetric in i and j.
    function automatic int unsigned rnd_idx(input int unsigned i, input int unsigned j,
                                            input int unsigned d);
        int unsigned lo;
        int unsigned hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * d - lo * (lo + 1) / 2 + (hi - lo - 1);
    endfunction

endpackage

// File: rtl/mskand_hpc2_sched_fifo.sv
// Result FIFO with registered head, wrap-around pointers for any depth, occupancy output.
module mskand_hpc2_sched_fifo
    import mskand_hpc2_sched_pkg::*;
#(
    parameter int unsigned Width = 3,
    parameter int unsigned Depth = 3,
    localparam int unsigned CntW = cnt_width(Depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             valid,
    output logic [CntW-1:0]  count
);
    localparam int unsigned PtrW = ptr_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q;
    logic [PtrW-1:0]  rd_q;
    logic [CntW-1:0]  cnt_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CntW'(Depth));
    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= next_ptr(wr_q);
            end
            if (do_pop) begin
                rd_q <= next_ptr(rd_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign rdata = mem_q[rd_q];
    assign valid = (cnt_q != '0);
    assign count = cnt_q;

    // The gadget cannot stall, so the credit scheme upstream must keep this from firing.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !do_pop));

endmodule

// File: rtl/mskand_hpc2_sched.sv
// Round-robin scheduler sharing one d-share HPC2 masked AND gadget between two requesters.
module mskand_hpc2_sched
    import mskand_hpc2_sched_pkg::*;
#(
    parameter int unsigned d         = 2,
    parameter int unsigned OUT_DEPTH = 3,
    localparam int unsigned hpc2rnd  = hpc2rnd_bits(d)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*d-1:0] req_a,
    input  logic [NUM_REQ*d-1:0] req_b,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [hpc2rnd-1:0]   rnd_in,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [d-1:0]         rsp_data,
    output logic [ID_W-1:0]      rsp_id
);
    localparam int unsigned CNT_W = cnt_width(OUT_DEPTH);

    logic [ID_W-1:0]    ptr_q;
    logic [1:0]         tag_v_q;
    logic [ID_W-1:0]    tag_id_q [2];
    logic [CNT_W-1:0]   fifo_cnt;
    logic               pop;
    logic               credit;
    logic               issue;
    logic [ID_W-1:0]    winner;
    int unsigned        occ;

    logic [d-1:0]       ina;
    logic [hpc2rnd-1:0] rnd;
    logic [d-1:0]       a_q;
    logic [d-1:0]       b_q;
    logic [hpc2rnd-1:0] r_q;
    logic [d-1:0]       gad_out;

    // A slot freed by this cycle's pop can be reused immediately, giving 1 op/cycle.
    always_comb begin
        occ    = 32'(fifo_cnt) + 32'(tag_v_q[0]) + 32'(tag_v_q[1]) - 32'(pop);
        credit = occ < OUT_DEPTH;
        issue  = credit && rnd_valid && (|req_valid);
        winner = req_valid[ptr_q] ? ptr_q : ~ptr_q;
    end

    assign req_ready = issue ? (NUM_REQ'(1) << winner) : '0;
    assign rnd_ready = issue;
    assign ina       = issue ? (winner[0] ? req_a[d +: d] : req_a[0 +: d]) : '0;
    assign rnd       = issue ? rnd_in : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            tag_v_q     <= '0;
            tag_id_q[0] <= '0;
            tag_id_q[1] <= '0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
        end else begin
            if (issue) begin
                ptr_q <= ~winner;
            end
            tag_v_q     <= {tag_v_q[0], issue};
            tag_id_q[0] <= issue ? winner : '0;
            tag_id_q[1] <= tag_id_q[0];
            a_q         <= ina;
            b_q         <= issue ? (winner[0] ? req_b[d +: d] : req_b[0 +: d]) : '0;
            r_q         <= rnd;
        end
    end

    // HPC2 gadget: A is refreshed with r_ij in cycle 1, then gated by B in cycle 2.
    for (genvar i = 0; i < d; i++) begin : g_share
        logic [d-1:0] u_d;
        logic [d-1:0] sr_d;
        logic [d-1:0] su_d;
        logic [d-1:0] u_q;
        logic [d-1:0] sr_q;
        logic [d-1:0] su_q;
        logic         ab_q;

        for (genvar j = 0; j < d; j++) begin : g_pair
            if (i == j) begin : g_diag
                assign u_d[j]  = 1'b0;
                assign sr_d[j] = 1'b0;
                assign su_d[j] = 1'b0;
            end else begin : g_cross
                localparam int unsigned RI = rnd_idx(i, j, d);
                assign u_d[j]  = ina[j] ^ rnd[RI];
                assign sr_d[j] = ~b_q[i] & r_q[RI];
                assign su_d[j] = b_q[i] & u_q[j];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                u_q  <= '0;
                sr_q <= '0;
                su_q <= '0;
                ab_q <= 1'b0;
            end else begin
                u_q  <= u_d;
                sr_q <= sr_d;
                su_q <= su_d;
                ab_q <= b_q[i] & a_q[i];
            end
        end

        assign gad_out[i] = ab_q ^ (^sr_q) ^ (^su_q);
    end

    logic [d:0] fifo_rdata;

    assign pop = rsp_valid && rsp_ready;

    mskand_hpc2_sched_fifo #(
        .Width (d + 1),
        .Depth (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_v_q[1]),
        .wdata ({tag_id_q[1], gad_out}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (rsp_valid),
        .count (fifo_cnt)
    );

    assign rsp_data = fifo_rdata[d-1:0];
    assign rsp_id   = fifo_rdata[d];

endmodule
